calc_core: RTL and testbench

Arithmetic and mode controller for the calculator datapath. It sits directly upstream of the LCD driver and owns power on/off and operation sequencing. It latches signed-magnitude operands on a start request and computes add, subtract or multiply; multiply uses a multi-cycle shift-add engine. It presents `S`, `SR` and `Sestado` in the encoding the LCD driver consumes.

---
 rtl/calc_core_if.sv | 27 ++
 rtl/calc_core.sv | 210 +++++++++++++++++++++
 tb/tb_calc_core.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/calc_core_if.sv
// Operand/result bundle between the calculator front end and calc_core.
// The master drives requests and operands; the slave returns result and status.
`timescale 1ns/1ps
interface calc_core_if;
  logic        pwr;
  logic        start;
  logic [1:0]  op;
  logic [7:0]  a;
  logic        SSA;
  logic [7:0]  b;
  logic        SSB;
  logic [15:0] S;
  logic        SR;
  logic [2:0]  Sestado;
  logic        busy;
  logic        done;

  modport master (
    output pwr, start, op, a, SSA, b, SSB,
    input  S, SR, Sestado, busy, done
  );

  modport slave (
    input  pwr, start, op, a, SSA, b, SSB,
    output S, SR, Sestado, busy, done
  );
endinterface

// File: rtl/calc_core.sv
// Calculator arithmetic/mode controller: power sequencing, signed-magnitude
// add/subtract and a shift-add multiplier, with LCD-ready registered outputs.
`timescale 1ns/1ps
module calc_core #(
  parameter int MUL_STEPS = 8
) (
  input logic         clk,
  input logic         rst,
  calc_core_if.slave  bus
);

  localparam int STEP_W = (MUL_STEPS > 1) ? $clog2(MUL_STEPS) : 1;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_MUL = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_INV = 2'b11;

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_IDLE   = 2'd1,
    ST_CALC   = 2'd2,
    ST_RESULT = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                pwr_q, start_q;
  logic [7:0]          a_q, b_q;
  logic                ssa_q, ssb_q;
  logic [1:0]          op_q;
  logic [15:0]         mcand_q, mcand_d;
  logic [7:0]          mplr_q, mplr_d;
  logic [15:0]         acc_q, acc_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [15:0]         s_q, s_d;
  logic                sr_q, sr_d;
  logic [2:0]          sestado_q, sestado_d;
  logic                busy_q, done_q;

  logic                pwr_edge, start_edge, latch_en, commit;
  logic                ssb_eff;
  logic [8:0]          as_mag;
  logic                as_sign;
  logic [15:0]         mul_sum, res_mag;
  logic                mul_last, res_sign;

  assign pwr_edge   = bus.pwr & ~pwr_q;
  assign start_edge = bus.start & ~start_q;
  assign latch_en   = (state_d == ST_CALC) && (state_q != ST_CALC);
  assign commit     = (state_q == ST_CALC) && (state_d == ST_RESULT);
  assign mul_sum    = acc_q + (mplr_q[0] ? mcand_q : 16'd0);
  assign mul_last   = (step_q == STEP_W'(MUL_STEPS - 1));

  // Signed-magnitude add/sub on latched operands; subtract flips B's sign.
  always_comb begin
    ssb_eff = (op_q == OP_SUB) ? ~ssb_q : ssb_q;
    as_mag  = 9'd0;
    as_sign = 1'b0;
    if (ssa_q == ssb_eff) begin
      as_mag  = {1'b0, a_q} + {1'b0, b_q};
      as_sign = ssa_q;
    end else if (a_q >= b_q) begin
      as_mag  = {1'b0, a_q - b_q};
      as_sign = ssa_q;
    end else begin
      as_mag  = {1'b0, b_q - a_q};
      as_sign = ssb_eff;
    end
  end

  // Final result selection; a zero magnitude is always reported as positive.
  always_comb begin
    res_mag  = 16'd0;
    res_sign = 1'b0;
    if (op_q == OP_MUL) begin
      res_mag  = mul_sum;
      res_sign = ssa_q ^ ssb_q;
    end else begin
      res_mag  = {7'd0, as_mag};
      res_sign = as_sign;
    end
    if (res_mag == 16'd0) begin
      res_sign = 1'b0;
    end else begin
      res_sign = res_sign;
    end
  end

  // Next-state logic; a power edge always wins over a start edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_OFF: begin
        if (pwr_edge) state_d = ST_IDLE;
        else          state_d = ST_OFF;
      end
      ST_IDLE, ST_RESULT: begin
        if (pwr_edge)                            state_d = ST_OFF;
        else if (start_edge && bus.op != OP_INV) state_d = ST_CALC;
        else                                     state_d = state_q;
      end
      ST_CALC: begin
        if (pwr_edge)                          state_d = ST_OFF;
        else if (op_q != OP_MUL || mul_last)   state_d = ST_RESULT;
        else                                   state_d = ST_CALC;
      end
      default: state_d = ST_OFF;
    endcase
  end

  // Multiplier engine: shift multiplicand left and multiplier right each step.
  always_comb begin
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    acc_d   = acc_q;
    step_d  = step_q;
    if (latch_en) begin
      mcand_d = {8'd0, bus.a};
      mplr_d  = bus.b;
      acc_d   = 16'd0;
      step_d  = {STEP_W{1'b0}};
    end else if (state_q == ST_CALC) begin
      mcand_d = mcand_q << 1;
      mplr_d  = mplr_q >> 1;
      acc_d   = mul_sum;
      step_d  = step_q + STEP_W'(1);
    end else begin
      mcand_d = mcand_q;
    end
  end

  // Output next values, derived from the state being entered.
  always_comb begin
    s_d       = s_q;
    sr_d      = sr_q;
    sestado_d = 3'd0;
    if (state_d == ST_OFF || state_q == ST_OFF) begin
      s_d  = 16'd0;
      sr_d = 1'b0;
    end else if (commit) begin
      s_d  = res_mag;
      sr_d = res_sign;
    end else begin
      s_d  = s_q;
    end
    case (state_d)
      ST_OFF:  sestado_d = 3'd0;
      ST_IDLE: sestado_d = 3'd1;
      ST_CALC: sestado_d = 3'd1;
      ST_RESULT: begin
        case (op_q)
          OP_ADD:  sestado_d = 3'd2;
          OP_MUL:  sestado_d = 3'd3;
          OP_SUB:  sestado_d = 3'd4;
          default: sestado_d = 3'd1;
        endcase
      end
      default: sestado_d = 3'd0;
    endcase
  end

  // All state and registered outputs; reset overrides every other event.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_OFF;
      pwr_q     <= 1'b0;
      start_q   <= 1'b0;
      a_q       <= 8'd0;
      b_q       <= 8'd0;
      ssa_q     <= 1'b0;
      ssb_q     <= 1'b0;
      op_q      <= 2'b00;
      mcand_q   <= 16'd0;
      mplr_q    <= 8'd0;
      acc_q     <= 16'd0;
      step_q    <= {STEP_W{1'b0}};
      s_q       <= 16'd0;
      sr_q      <= 1'b0;
      sestado_q <= 3'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pwr_q     <= bus.pwr;
      start_q   <= bus.start;
      if (latch_en) begin
        a_q   <= bus.a;
        b_q   <= bus.b;
        ssa_q <= bus.SSA;
        ssb_q <= bus.SSB;
        op_q  <= bus.op;
      end
      mcand_q   <= mcand_d;
      mplr_q    <= mplr_d;
      acc_q     <= acc_d;
      step_q    <= step_d;
      s_q       <= s_d;
      sr_q      <= sr_d;
      sestado_q <= sestado_d;
      busy_q    <= (state_d == ST_CALC);
      done_q    <= commit;
    end
  end

  assign bus.S       = s_q;
  assign bus.SR      = sr_q;
  assign bus.Sestado = sestado_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_calc_core.sv
// Directed bench for calc_core: vector table for arithmetic results plus
// hand-written sequences for power, abort, reset and edge-detect corners.
`timescale 1ns/1ps
module tb_calc_core;

  typedef struct {
    logic [1:0]  op;
    logic [7:0]  a;
    logic        ssa;
    logic [7:0]  b;
    logic        ssb;
    logic [15:0] s;
    logic        sr;
    logic [2:0]  st;
    int          lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  vec_t vecs [10];

  calc_core_if bus ();

  calc_core #(.MUL_STEPS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_S"}, 0, 32'(bus.S), 32'd0);
    chk({name, "_SR"}, 0, 32'(bus.SR), 32'd0);
    chk({name, "_Sestado"}, 0, 32'(bus.Sestado), 32'd0);
    chk({name, "_busy"}, 0, 32'(bus.busy), 32'd0);
    chk({name, "_done"}, 0, 32'(bus.done), 32'd0);
  endtask

  // Start one computation, scramble all inputs while busy, wait for done.
  task automatic run_vec(input vec_t v, input int idx);
    int   lat;
    int   busy_cnt;
    logic got;
    bus.op = v.op; bus.a = v.a; bus.SSA = v.ssa; bus.b = v.b; bus.SSB = v.ssb;
    bus.start = 1'b1;
    tick();
    bus.a = ~v.a; bus.b = ~v.b; bus.SSA = ~v.ssa; bus.SSB = ~v.ssb;
    bus.op = 2'b11; bus.start = 1'b0;
    lat = 1;
    busy_cnt = bus.busy ? 1 : 0;
    got = bus.done;
    while (!got && lat < 20) begin
      tick();
      lat++;
      if (bus.busy) busy_cnt++;
      got = bus.done;
    end
    chk("done_seen", idx, 32'(got), 32'd1);
    chk("latency", idx, 32'(lat), 32'(v.lat));
    chk("busy_cycles", idx, 32'(busy_cnt), 32'(v.lat - 1));
    chk("S", idx, 32'(bus.S), 32'(v.s));
    chk("SR", idx, 32'(bus.SR), 32'(v.sr));
    chk("Sestado", idx, 32'(bus.Sestado), 32'(v.st));
    tick();
    chk("done_pulse", idx, 32'(bus.done), 32'd0);
    chk("hold_S", idx, 32'(bus.S), 32'(v.s));
  endtask

  initial begin
    int   cnt;
    logic got;

    vecs[0] = '{2'b00, 8'd100, 1'b0, 8'd30,  1'b1, 16'd70,    1'b0, 3'd2, 2};
    vecs[1] = '{2'b10, 8'd5,   1'b1, 8'd10,  1'b0, 16'd15,    1'b1, 3'd4, 2};
    vecs[2] = '{2'b01, 8'd255, 1'b1, 8'd255, 1'b0, 16'd65025, 1'b1, 3'd3, 9};
    vecs[3] = '{2'b01, 8'd0,   1'b0, 8'd7,   1'b1, 16'd0,     1'b0, 3'd3, 9};
    vecs[4] = '{2'b00, 8'd20,  1'b0, 8'd20,  1'b1, 16'd0,     1'b0, 3'd2, 2};
    vecs[5] = '{2'b10, 8'd10,  1'b0, 8'd200, 1'b0, 16'd190,   1'b1, 3'd4, 2};
    vecs[6] = '{2'b00, 8'd255, 1'b0, 8'd255, 1'b0, 16'd510,   1'b0, 3'd2, 2};
    vecs[7] = '{2'b01, 8'd13,  1'b0, 8'd11,  1'b0, 16'd143,   1'b0, 3'd3, 9};
    vecs[8] = '{2'b10, 8'd50,  1'b1, 8'd20,  1'b1, 16'd30,    1'b1, 3'd4, 2};
    vecs[9] = '{2'b01, 8'd200, 1'b1, 8'd3,   1'b1, 16'd600,   1'b0, 3'd3, 9};

    bus.pwr = 1'b0; bus.start = 1'b0; bus.op = 2'b00;
    bus.a = 8'd0; bus.SSA = 1'b0; bus.b = 8'd0; bus.SSB = 1'b0;
    rst = 1'b1;
    tick(); tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // Power on
    bus.pwr = 1'b1; tick();
    chk("pwr_on_Sestado", 0, 32'(bus.Sestado), 32'd1);
    chk("pwr_on_S", 0, 32'(bus.S), 32'd0);
    chk("pwr_on_SR", 0, 32'(bus.SR), 32'd0);
    bus.pwr = 1'b0; tick();

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Start edge on the very cycle done is high is accepted
    bus.op = 2'b00; bus.a = 8'd1; bus.SSA = 1'b0; bus.b = 8'd2; bus.SSB = 1'b0;
    bus.start = 1'b1; tick();
    bus.start = 1'b0; tick();
    chk("b2b_first_done", 0, 32'(bus.done), 32'd1);
    chk("b2b_first_S", 0, 32'(bus.S), 32'd3);
    bus.op = 2'b01; bus.a = 8'd3; bus.b = 8'd4;
    bus.start = 1'b1; tick();
    chk("b2b_busy", 0, 32'(bus.busy), 32'd1);
    chk("b2b_Sestado", 0, 32'(bus.Sestado), 32'd1);
    bus.start = 1'b0;
    cnt = 0; got = 1'b0;
    while (!got && cnt < 20) begin tick(); cnt++; got = bus.done; end
    chk("b2b_done_seen", 0, 32'(got), 32'd1);
    chk("b2b_S", 0, 32'(bus.S), 32'd12);
    chk("b2b_Sestado_res", 0, 32'(bus.Sestado), 32'd3);
    tick();

    // Start held high across a result must not retrigger
    bus.op = 2'b00; bus.a = 8'd9; bus.b = 8'd1;
    bus.start = 1'b1; tick(); tick();
    chk("held_done", 0, 32'(bus.done), 32'd1);
    chk("held_S", 0, 32'(bus.S), 32'd10);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("held_busy", i, 32'(bus.busy), 32'd0);
      chk("held_no_done", i, 32'(bus.done), 32'd0);
    end
    bus.start = 1'b0; tick();

    // Invalid op is ignored
    bus.op = 2'b11; bus.a = 8'd77;
    bus.start = 1'b1; tick(); tick();
    chk("inv_busy", 0, 32'(bus.busy), 32'd0);
    chk("inv_Sestado", 0, 32'(bus.Sestado), 32'd2);
    chk("inv_S", 0, 32'(bus.S), 32'd10);
    bus.start = 1'b0; tick();

    // Simultaneous pwr and start edges from RESULT: power wins
    bus.op = 2'b00; bus.pwr = 1'b1; bus.start = 1'b1; tick();
    chk("both_Sestado", 0, 32'(bus.Sestado), 32'd0);
    chk("both_busy", 0, 32'(bus.busy), 32'd0);
    chk("both_S", 0, 32'(bus.S), 32'd0);
    bus.pwr = 1'b0; bus.start = 1'b0; tick();
    bus.start = 1'b1; tick(); tick();
    chk("off_start_Sestado", 0, 32'(bus.Sestado), 32'd0);
    chk("off_start_busy", 0, 32'(bus.busy), 32'd0);
    bus.start = 1'b0; tick();

    // Power abort at N+4 of a multiply
    bus.pwr = 1'b1; tick(); bus.pwr = 1'b0; tick();
    run_vec(vecs[7], 100);
    bus.op = 2'b01; bus.a = 8'd255; bus.b = 8'd255;
    bus.start = 1'b1; tick();
    bus.start = 1'b0; tick(); tick(); tick();
    chk("abort_busy_before", 0, 32'(bus.busy), 32'd1);
    bus.pwr = 1'b1; tick();
    check_all_zero("abort");
    bus.pwr = 1'b0;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.done) cnt++;
    end
    chk("abort_no_done", 0, 32'(cnt), 32'd0);

    // Reset mid-CALC
    bus.pwr = 1'b1; tick(); bus.pwr = 1'b0; tick();
    run_vec(vecs[0], 200);
    bus.op = 2'b01; bus.a = 8'd9; bus.b = 8'd9;
    bus.start = 1'b1; tick();
    bus.start = 1'b0; tick(); tick();
    rst = 1'b1; tick();
    check_all_zero("rst_calc");
    rst = 1'b0; tick(); tick();
    chk("rst_stays_off", 0, 32'(bus.Sestado), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
